// File: rtl/audio_axi_capture_fifo.sv
// AXI4-Lite slave buffering multi-channel audio frames in a FIFO for software readout.
// Define AUDIO_CAPTURE_PEAK_EN to add per-channel clear-on-read peak registers at 0x20+4*ch.
module audio_axi_capture_fifo #(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 6,
   parameter int SAMPLE_WIDTH         = 24,
   parameter int NUM_CHANNELS         = 2,
   parameter int FIFO_DEPTH           = 16
) (
   input  logic                                    s00_axi_aclk,
   input  logic                                    s00_axi_aresetn,
   input  logic                                    audio_valid,
   input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]    audio_frame,
   output logic                                    irq,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]         s00_axi_awaddr,
   input  logic [2:0]                              s00_axi_awprot,
   input  logic                                    s00_axi_awvalid,
   output logic                                    s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]         s00_axi_wdata,
   input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0]     s00_axi_wstrb,
   input  logic                                    s00_axi_wvalid,
   output logic                                    s00_axi_wready,
   output logic [1:0]                              s00_axi_bresp,
   output logic                                    s00_axi_bvalid,
   input  logic                                    s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]         s00_axi_araddr,
   input  logic [2:0]                              s00_axi_arprot,
   input  logic                                    s00_axi_arvalid,
   output logic                                    s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]         s00_axi_rdata,
   output logic [1:0]                              s00_axi_rresp,
   output logic                                    s00_axi_rvalid,
   input  logic                                    s00_axi_rready
);
   localparam int AW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = NUM_CHANNELS * SAMPLE_WIDTH;
   localparam int IW = C_S00_AXI_ADDR_WIDTH - 2;
   localparam int LW = (AW > 8) ? 8 : AW;
   localparam int SW = SAMPLE_WIDTH;

   logic [FW-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr, level;
   logic           empty, full;
   logic           ctrl_en, ctrl_irq_en, ovf;
   logic [8:0]     thresh;
   logic [15:0]    ovf_cnt, ovf_base;
   logic [IW-1:0]  widx, ridx;
   logic           wr_hs, rd_hs, flush, ovf_clr;
   logic           push_req, push, pop, drop;
   logic [FW-1:0]  head;
   logic [31:0]    rd_val;
   logic           unused;

   assign s00_axi_bresp = 2'b00;
   assign s00_axi_rresp = 2'b00;
   assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                     s00_axi_wdata[31:9], s00_axi_wstrb[3:2]};

   assign widx  = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
   assign ridx  = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
   assign wr_hs = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
   assign rd_hs = s00_axi_arready & s00_axi_arvalid;

   assign level = wr_ptr - rd_ptr;
   assign empty = (level == '0);
   assign full  = (level == AW'(FIFO_DEPTH));
   assign head  = mem[rd_ptr[AW-2:0]];

   assign flush    = wr_hs & (widx == IW'(0)) & s00_axi_wstrb[0] & s00_axi_wdata[1];
   assign ovf_clr  = wr_hs & (widx == IW'(1)) & s00_axi_wstrb[0] & s00_axi_wdata[2];
   // Flush wins over both a same-cycle pop and push; a discarded push is not a drop.
   assign pop      = rd_hs & (ridx == IW'(4 + NUM_CHANNELS - 1)) & ~empty & ~flush;
   assign push_req = audio_valid & ctrl_en & ~flush;
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;
   assign ovf_base = ovf_clr ? 16'h0 : ovf_cnt;

`ifdef AUDIO_CAPTURE_PEAK_EN
   logic [SW-1:0] peak [NUM_CHANNELS];

   function automatic logic [SW-1:0] abs_sat(input logic [SW-1:0] s);
      if (!s[SW-1])
         return s;
      else if (s == {1'b1, {(SW-1){1'b0}}})
         return {1'b0, {(SW-1){1'b1}}};
      else
         return -s;
   endfunction

   always_ff @(posedge s00_axi_aclk) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (!s00_axi_aresetn)
            peak[ch] <= '0;
         else if (rd_hs && ridx == IW'(8 + ch))
            peak[ch] <= push ? abs_sat(audio_frame[ch*SW +: SW]) : '0;
         else if (push && abs_sat(audio_frame[ch*SW +: SW]) > peak[ch])
            peak[ch] <= abs_sat(audio_frame[ch*SW +: SW]);
      end
   end
`endif

   always_comb begin
      rd_val = '0;
      case (ridx)
         IW'(0): rd_val = {29'h0, ctrl_irq_en, 1'b0, ctrl_en};
         IW'(1): rd_val = {16'h0, 8'(level[LW-1:0]), 5'h0, ovf, full, empty};
         IW'(2): rd_val = {23'h0, thresh};
         IW'(3): rd_val = {16'h0, ovf_cnt};
         default: begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
               if (ridx == IW'(4 + ch) && !empty)
                  rd_val = 32'($signed(head[ch*SW +: SW]));
`ifdef AUDIO_CAPTURE_PEAK_EN
               if (ridx == IW'(8 + ch))
                  rd_val = 32'(peak[ch]);
`endif
            end
         end
      endcase
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (push)
         mem[wr_ptr[AW-2:0]] <= audio_frame;
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         s00_axi_awready <= 1'b0;
         s00_axi_wready  <= 1'b0;
         s00_axi_bvalid  <= 1'b0;
         s00_axi_arready <= 1'b0;
         s00_axi_rvalid  <= 1'b0;
         s00_axi_rdata   <= '0;
         irq             <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         ctrl_en         <= 1'b0;
         ctrl_irq_en     <= 1'b0;
         thresh          <= '0;
         ovf             <= 1'b0;
         ovf_cnt         <= '0;
      end else begin
         // Ready is a single-cycle pulse; the !ready term stops a retrigger on the handshake edge.
         s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
         s00_axi_wready  <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
         s00_axi_arready <= s00_axi_arvalid & ~s00_axi_rvalid & ~s00_axi_arready;

         if (wr_hs)
            s00_axi_bvalid <= 1'b1;
         else if (s00_axi_bready)
            s00_axi_bvalid <= 1'b0;

         if (rd_hs) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rd_val;
         end else if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
         end

         if (wr_hs && widx == IW'(0) && s00_axi_wstrb[0]) begin
            ctrl_en     <= s00_axi_wdata[0];
            ctrl_irq_en <= s00_axi_wdata[2];
         end
         if (wr_hs && widx == IW'(2)) begin
            if (s00_axi_wstrb[0]) thresh[7:0] <= s00_axi_wdata[7:0];
            if (s00_axi_wstrb[1]) thresh[8]   <= s00_axi_wdata[8];
         end

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end

         if (drop) begin
            ovf     <= 1'b1;
            ovf_cnt <= (ovf_base == 16'hFFFF) ? ovf_base : ovf_base + 16'h1;
         end else if (ovf_clr) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
         end

         irq <= ctrl_irq_en & (thresh != '0) & (32'(level) >= 32'(thresh));
      end
   end
endmodule

// File: tb/tb_audio_axi_capture_fifo.sv
// Bench for audio_axi_capture_fifo: register vector table, frame model and read scoreboard.
module tb_audio_axi_capture_fifo;
   logic        clk = 0, rstn = 0;
   logic        audio_valid = 0;
   logic [47:0] audio_frame = '0;
   logic        irq;
   logic [5:0]  awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic [31:0] wdata = '0, rdata;
   logic [3:0]  wstrb = '0;
   logic [1:0]  bresp, rresp;
   logic        arvalid = 0, arready, rvalid, rready = 0;

   audio_axi_capture_fifo dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .audio_valid(audio_valid),
      .audio_frame(audio_frame), .irq(irq),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
      .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
      .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
      .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
      .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
      .s00_axi_rready(rready));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   logic [31:0] sb[$];
   string       sbn[$];
   logic [47:0] q[$];
   bit          m_en = 0, m_ovf_flag = 0;
   int          m_ovf = 0;
   logic [23:0] m_peak0 = '0;

   typedef struct {
      string       name;
      bit          wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic timeout(input string n);
      checks++;
      errors++;
      $display("FAIL %s: handshake timeout", n);
   endtask

   function automatic logic [31:0] sext(input logic [23:0] s);
      return {{8{s[23]}}, s};
   endfunction

   function automatic logic [23:0] abs24(input logic [23:0] s);
      if (!s[23]) return s;
      if (s == 24'h800000) return 24'h7FFFFF;
      return -s;
   endfunction

   function automatic logic [47:0] rnd_frame();
      logic [47:0] f;
      f[23:0]  = 24'($urandom);
      f[47:24] = 24'($urandom);
      return f;
   endfunction

   function automatic void model_push(input logic [47:0] f);
      if (!m_en) return;
      if (q.size() < 16) begin
         q.push_back(f);
         if (abs24(f[23:0]) > m_peak0) m_peak0 = abs24(f[23:0]);
      end else begin
         m_ovf++;
         m_ovf_flag = 1;
      end
   endfunction

   task automatic push_frame(input logic [23:0] c0, input logic [23:0] c1);
      @(negedge clk);
      audio_valid = 1;
      audio_frame = {c1, c0};
      @(posedge clk);
      model_push({c1, c0});
      @(negedge clk);
      audio_valid = 0;
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit push_hs);
      bit ok = 0;
      logic [47:0] fr = rnd_frame();
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (awready && wready) begin ok = 1; break; end
      end
      if (!ok) begin
         timeout("aw_handshake");
         awvalid = 0; wvalid = 0;
         return;
      end
      if (push_hs) begin audio_valid = 1; audio_frame = fr; end
      @(posedge clk);
      if (push_hs && !(a == 6'h00 && s[0] && d[1])) model_push(fr);
      if (a == 6'h00 && s[0]) begin
         if (d[1]) q.delete();
         m_en = d[0];
      end
      if (a == 6'h04 && s[0] && d[2]) begin m_ovf = 0; m_ovf_flag = 0; end
      @(negedge clk);
      awvalid = 0; wvalid = 0; audio_valid = 0; bready = 1;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (bvalid) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) timeout("bvalid");
      else chk("bresp", 32'(bresp), 32'h0);
      @(posedge clk);
      @(negedge clk);
      bready = 0;
   endtask

   task automatic axi_read(input logic [5:0] a, input bit push_hs);
      bit ok = 0;
      logic [31:0] e;
      string n;
      logic [47:0] fr = rnd_frame();
      e = sb.pop_front();
      n = sbn.pop_front();
      @(negedge clk);
      araddr = a; arvalid = 1; rready = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (arready) begin ok = 1; break; end
      end
      if (!ok) begin
         timeout({n, "_ar"});
         arvalid = 0;
         return;
      end
      if (push_hs) begin audio_valid = 1; audio_frame = fr; end
      @(posedge clk);
      if (a == 6'h14 && q.size() > 0) void'(q.pop_front());
      if (a == 6'h20) m_peak0 = '0;
      if (push_hs) model_push(fr);
      @(negedge clk);
      arvalid = 0; audio_valid = 0; rready = 1;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (rvalid) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) timeout({n, "_r"});
      else begin
         chk(n, rdata, e);
         chk("rresp", 32'(rresp), 32'h0);
      end
      @(posedge clk);
      @(negedge clk);
      rready = 0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [31:0] e, input string n,
                     input bit push_hs = 0);
      sb.push_back(e);
      sbn.push_back(n);
      axi_read(a, push_hs);
   endtask

   initial begin
      vecs = '{
         '{"ctrl_rst",    0, 6'h00, 32'h0,        4'h0, 32'h0},
         '{"status_rst",  0, 6'h04, 32'h0,        4'h0, 32'h1},
         '{"ovf_rst",     0, 6'h0C, 32'h0,        4'h0, 32'h0},
         '{"thresh_rst",  0, 6'h08, 32'h0,        4'h0, 32'h0},
         '{"thr_wr",      1, 6'h08, 32'h1FF,      4'hF, 32'h0},
         '{"thresh_all",  0, 6'h08, 32'h0,        4'h0, 32'h1FF},
         '{"thr_wr_b0",   1, 6'h08, 32'hFFFFFE00, 4'h1, 32'h0},
         '{"thresh_strb", 0, 6'h08, 32'h0,        4'h0, 32'h100},
         '{"thr_clr",     1, 6'h08, 32'h0,        4'hF, 32'h0},
         '{"unmap_wr",    1, 6'h3C, 32'hFFFFFFFF, 4'hF, 32'h0},
         '{"unmapped",    0, 6'h3C, 32'h0,        4'h0, 32'h0},
         '{"ctrl_wr_s0",  1, 6'h00, 32'h7,        4'h0, 32'h0},
         '{"ctrl_nostrb", 0, 6'h00, 32'h0,        4'h0, 32'h0},
         '{"ctrl_wr",     1, 6'h00, 32'h6,        4'h1, 32'h0},
         '{"ctrl_irqen",  0, 6'h00, 32'h0,        4'h0, 32'h4},
         '{"ctrl_wr0",    1, 6'h00, 32'h0,        4'hF, 32'h0},
         '{"ch2_unmap",   0, 6'h18, 32'h0,        4'h0, 32'h0},
         '{"peak1_init",  0, 6'h24, 32'h0,        4'h0, 32'h0},
         '{"head_empty",  0, 6'h10, 32'h0,        4'h0, 32'h0}
      };

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {25'h0, awready, wready, bvalid, arready, rvalid, irq, 1'b0}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rstn = 1;

      foreach (vecs[i]) begin
         if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0);
         else            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
      chk("irq_idle", 32'(irq), 32'h0);

      // Disabled capture ignores frames, then a basic frame round trip
      push_frame(24'h111111, 24'h222222);
      rd(6'h04, 32'h1, "status_dis");
      axi_write(6'h00, 32'h1, 4'hF, 0);
      push_frame(24'h000123, 24'hFFFFFE);
      rd(6'h04, 32'h100, "status_lvl1");
      rd(6'h10, 32'h00000123, "ch0_head");
      rd(6'h14, 32'hFFFFFFFE, "ch1_pop");
      rd(6'h04, 32'h1, "status_after_pop");

      // Overflow and its W1C
      for (int i = 0; i < 18; i++) push_frame(24'(i * 3 + 1), 24'(~i));
      rd(6'h04, 32'h1006, "status_full_ovf");
      rd(6'h0C, 32'h2, "ovf_count");
      axi_write(6'h04, 32'h4, 4'hF, 0);
      rd(6'h04, 32'h1002, "status_w1c");
      rd(6'h0C, 32'h0, "ovf_cleared");
      rd(6'h10, sext(q[0][23:0]), "order_head0");

      // Threshold interrupt
      axi_write(6'h00, 32'h3, 4'hF, 0);
      axi_write(6'h08, 32'h4, 4'hF, 0);
      axi_write(6'h00, 32'h5, 4'hF, 0);
      for (int i = 0; i < 3; i++) push_frame(24'($urandom), 24'($urandom));
      chk("irq_lvl3", 32'(irq), 32'h0);
      push_frame(24'h800000, 24'h7FFFFF);
      chk("irq_same_cycle", 32'(irq), 32'h0);
      @(negedge clk);
      chk("irq_lvl4", 32'(irq), 32'h1);
      rd(6'h14, sext(q[0][47:24]), "irq_pop");
      chk("irq_after_pop", 32'(irq), 32'h0);

      // Push into a full FIFO alongside a pop, then flush with a push
      axi_write(6'h00, 32'h3, 4'hF, 0);
      rd(6'h04, 32'h1, "status_flushed");
      rd(6'h00, 32'h1, "flush_selfclr");
      for (int i = 0; i < 16; i++) push_frame(24'($urandom), 24'($urandom));
      rd(6'h14, sext(q[0][47:24]), "full_pop", 1);
      rd(6'h04, 32'h1002, "full_push_pop");
      rd(6'h10, sext(q[0][23:0]), "head_after_pp");
      push_frame(24'h0, 24'h0);
      rd(6'h0C, 32'h1, "ovf_one");
      axi_write(6'h00, 32'h3, 4'hF, 1);
      rd(6'h04, 32'h5, "flush_with_push");
      rd(6'h0C, 32'h1, "ovf_unchanged");
      rd(6'h14, 32'h0, "empty_pop_zero");
      rd(6'h04, 32'h5, "empty_no_pop");

`ifdef AUDIO_CAPTURE_PEAK_EN
      rd(6'h20, 32'(m_peak0), "peak_prior");
      push_frame(24'h000010, 24'h0);
      push_frame(24'hFFFF00, 24'h800000);
      push_frame(24'h7FFFF0, 24'h0);
      rd(6'h20, 32'h007FFFF0, "peak0");
      rd(6'h20, 32'h0, "peak0_cleared");
      rd(6'h24, 32'h007FFFFF, "peak1_sat");
`else
      push_frame(24'h7FFFF0, 24'h0);
      rd(6'h20, 32'h0, "peak_absent");
`endif

      // Reset mid-transaction drops a pending response
      @(negedge clk);
      araddr = 6'h04; arvalid = 1;
      repeat (3) @(negedge clk);
      arvalid = 0;
      rstn = 0;
      @(negedge clk);
      chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
      rstn = 1;
      q.delete(); m_en = 0; m_ovf = 0; m_ovf_flag = 0;
      rd(6'h04, 32'h1, "status_post_rst");
      rd(6'h0C, 32'h0, "ovf_post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/audio_axi_capture_fifo.md
Name: audio_axi_capture_fifo

Overview:
- AXI4-Lite slave that captures multi-channel audio frames into an on-chip FIFO for software readout.
- Generalises the single-bank 4-register audio-to-AXI slave with the following additions:
  - parametrised sample width and channel count
  - buffered capture with overflow accounting
  - a level-threshold interrupt
- Sits between the audio mixer datapath and the PS AXI interconnect on the S00_AXI port.

Parameters:
- C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S00_AXI_ADDR_WIDTH, 6, AXI byte-address width.
- SAMPLE_WIDTH, 24, bits per channel sample, range 8..32.
- NUM_CHANNELS, 2, channels per frame, range 1..4.
- FIFO_DEPTH, 16, frames buffered; must be a power of 2, range 2..256.

Ports:
- s00_axi_aclk  in  1  Single clock for all logic.
- s00_axi_aresetn  in  1  Reset, synchronous, active-low.
- audio_valid  in  1  One-cycle frame strobe.
- audio_frame  in  NUM_CHANNELS*SAMPLE_WIDTH  Frame data; channel 0 in the LSBs; two's complement.
- irq  out  1  Level interrupt.
- s00_axi_awaddr/awprot/awvalid/awready  AXI4-Lite write-address channel; awaddr width is C_S00_AXI_ADDR_WIDTH.
- s00_axi_wdata/wstrb/wvalid/wready  AXI4-Lite write-data channel; 32 data bits, 4 strobe bits.
- s00_axi_bresp/bvalid/bready  AXI4-Lite write-response channel.
- s00_axi_araddr/arprot/arvalid/arready  AXI4-Lite read-address channel.
- s00_axi_rdata/rresp/rvalid/rready  AXI4-Lite read-data channel.

Behaviour:
- Reset values (while s00_axi_aresetn=0 at a clock edge):
  - all ready/valid outputs 0; bresp, rresp, rdata 0; irq 0
  - FIFO empty; CTRL=0, THRESH=0, OVF_COUNT=0; overflow flag 0
- Write channel:
  - awready and wready pulse together for one cycle when awvalid&wvalid&!bvalid.
  - The write takes effect on that same edge.
  - bvalid rises on the next cycle and holds until bready.
  - bresp is always OKAY (00).
  - wstrb is honoured per byte on CTRL and THRESH.
- Read channel:
  - arready pulses for one cycle when arvalid&!rvalid.
  - rdata is registered and rvalid is asserted on the next cycle, held until rready.
  - rresp is always OKAY.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map (byte address, addr[1:0] ignored):
  - 0x00 CTRL, RW: bit0 enable; bit1 flush (self-clearing, reads 0); bit2 irq_en.
  - 0x04 STATUS: bit0 empty (RO); bit1 full (RO); bit2 overflow (sticky, W1C); bits[15:8] level (RO, zero-extended).
  - 0x08 THRESH, RW: bits[8:0].
  - 0x0C OVF_COUNT, RO: 16-bit count of dropped frames, saturates at 0xFFFF, cleared by the W1C of STATUS bit2.
  - 0x10+4*ch, RO, ch < NUM_CHANNELS: head-frame sample for channel ch, sign-extended to 32 bits.
    - Reading ch=NUM_CHANNELS-1 pops the FIFO at the arready handshake.
    - With the FIFO empty these reads return 0 and do not pop.
- Push:
  - On audio_valid&enable: if not full, write audio_frame at the tail.
  - If full, drop the frame, set overflow, increment OVF_COUNT.
  - With enable=0, audio_valid is ignored.
- Simultaneous push and pop: both occur and level is unchanged; push into a full FIFO with a same-cycle pop succeeds.
- Flush:
  - Empties the FIFO in one cycle.
  - A push in the same cycle is discarded and not counted.
  - A pop in the same cycle is ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; level = wr_ptr-rd_ptr.
- irq is registered: irq = irq_en & (THRESH!=0) & (level >= THRESH).
- Reset mid-transaction: any pending bvalid/rvalid is dropped; FIFO contents are discarded.

Optional Feature:
- Macro AUDIO_CAPTURE_PEAK_EN.
- Defined:
  - Per-channel peak registers at 0x20+4*ch hold max |sample| of pushed frames, zero-extended.
  - |most-negative| saturates to 2^(SAMPLE_WIDTH-1)-1.
  - A read returns the current peak and clears it to 0 at the read handshake.
  - A push in the same cycle as the clearing read loads that frame's |sample|.
- Undefined: no peak logic; 0x20..0x2C read 0.

Test Plan:
- Reset, then read 0x00/0x04/0x0C -> 0x0, 0x1 (empty), 0x0; all responses OKAY; irq=0.
- Write CTRL=0x1; push frames ch0=0x000123, ch1=0xFFFFFE -> STATUS level=1. Read 0x10 -> 0x00000123, no pop. Read 0x14 -> 0xFFFFFFFE, then STATUS=0x1.
- With enable=1, push 18 frames into the FIFO (depth 16) -> STATUS=0x1006 (level 16, full, overflow), OVF_COUNT=2. Write STATUS=0x4 -> overflow clears, OVF_COUNT=0.
- THRESH=4, CTRL=0x5: push 3 frames -> irq=0; push a 4th -> irq=1 one cycle later. Pop one -> irq=0.
- With the FIFO full, assert audio_valid on the same cycle as the ch1 pop handshake -> level stays 16, no overflow. Write CTRL=0x3 with audio_valid high -> level=0, OVF_COUNT unchanged.
- AUDIO_CAPTURE_PEAK_EN: push ch0 samples 0x000010, 0xFFFF00, 0x7FFFF0 -> read 0x20 returns 0x007FFFF0, then 0x0.
